syst_out_deskew: RTL and testbench
==================================

Name: syst_out_deskew

Overview:
- Output-side collector for the 5x5 weight-stationary systolic array (syst_ws).
- The array emits one partial-sum row per pass, staggered in time: column j appears j cycles after column 0. The array has no stall input.
- This block captures each column's 20-bit result into a per-column FIFO and re-aligns the five columns into one row word.
- It presents that word downstream over a valid/ready handshake and flags overflow when downstream stalls too long.

Parameters:
- COLS, 5, number of array columns.
- DW, 20, result width per column (matches y*_o).
- DEPTH, 8, entries per column FIFO; power of two, >=2.
- CNTW, 16, width of the row counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all FIFOs, flags and counter.
- y_i  in  COLS*DW  column results; column j at bits [j*DW +: DW].
- yvalid_i  in  COLS  per-column strobe; bit j means y_i column j is valid this cycle.
- row_o  out  COLS*DW  aligned row, same packing as y_i.
- row_valid_o  out  1  row_o holds a complete row.
- row_ready_i  in  1  downstream accepts row_o.
- rows_out_o  out  CNTW  count of rows accepted; wraps modulo 2^CNTW.
- ovf_o  out  COLS  sticky per-column overflow flag.
- idle_o  out  1  all column FIFOs empty.

Behaviour:
- Reset (rst_i low, asynchronous):
  - all FIFO pointers and occupancies are 0;
  - row_valid_o=0, row_o=0, rows_out_o=0, ovf_o=0, idle_o=1.
- Reset release is used synchronously.
- Push, column j: when yvalid_i[j]=1 and FIFO j is not full, y_i column j is written at the tail on the clock edge.
- Pop: fire = row_valid_o & row_ready_i. On fire, every column FIFO pops its head simultaneously and rows_out_o increments by 1.
- row_valid_o = 1 exactly when all COLS FIFOs are non-empty. It is derived from registered occupancy only; it never depends combinationally on yvalid_i.
- row_o is the concatenation of the FIFO heads. row_o is 0 whenever row_valid_o=0. It is stable while row_valid_o=1 and row_ready_i=0.
- Latency: row_valid_o rises the cycle after the edge that writes the last missing column. With the nominal skew this is 1 cycle after column COLS-1 is written, i.e. COLS cycles after column 0's write edge.
- Simultaneous push and pop on the same column in one cycle:
  - both take effect; occupancy is unchanged;
  - this also applies to a full FIFO — the push is accepted because the pop frees the slot that cycle.
- Overflow: a push to a full FIFO with no simultaneous pop is dropped. The FIFO contents are unchanged and ovf_o[j] is set.
  - ovf_o[j] stays set until flush_i or reset.
  - Subsequent behaviour is defined but rows are misaligned; recovery is by flush.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full/empty are decided by an occupancy counter of width log2(DEPTH)+1.
- flush_i = 1:
  - on the next edge, all occupancies, ovf_o and rows_out_o become 0, and row_valid_o=0 the following cycle;
  - flush takes priority over a simultaneous push or pop in the same cycle;
  - pushes in the flush cycle are discarded.
- rows_out_o wraps from 2^CNTW-1 to 0 without flagging.
- Reset mid-row: partial columns are discarded and the state returns to reset values immediately.
- idle_o = 1 exactly when every occupancy is 0 (registered state).

Decomposition:
- Shared package syst_pkg holds:
  - localparams COLS_DEF=5 and DW_DEF=20;
  - the typedef col_word_t (logic [DW-1:0]);
  - the typedef row_word_t (packed array of COLS col_word_t).
- Natural sub-module: syst_col_fifo, a single-column synchronous FIFO with:
  - push, pop, flush;
  - outputs full, empty, head;
  - a sticky overflow output.
- syst_col_fifo is instantiated COLS times in a generate loop. The top level adds the all-non-empty AND, the output zero-masking, and the row counter.

Test Plan:
- Skewed single row: after reset, column j is valid with value j+1 at cycle t0+j, row_ready_i=1 -> row_valid_o high for one cycle at t0+5 with row_o={5,4,3,2,1} (col4..col0), rows_out_o=1, idle_o returns to 1.
- Backpressure:
  - setup: row_ready_i=0, three back-to-back skewed rows, row r column j value = 10r+j;
  - during stall: row_valid_o held, row_o stable at row 0;
  - after row_ready_i=1: rows 0, 1, 2 emerge on consecutive cycles, then rows_out_o=3.
- Overflow:
  - setup: row_ready_i=0, 9 pushes to column 0 only (DEPTH=8);
  - expected: ovf_o=5'b00001 and occupancy of column 0 is 8; the 9th value is never output;
  - after flush_i: ovf_o=0, idle_o=1.
- Full with concurrent pop: all FIFOs full, row_ready_i=1 and all columns push in the same cycle -> no ovf_o set, row count conserved, data order preserved.
- Flush priority and reset mid-row:
  - flush_i asserted in the same cycle as pushes and a pop -> all FIFOs empty, rows_out_o=0;
  - rst_i pulsed low after only columns 0..2 are written -> row_valid_o=0 and idle_o=1 immediately (asynchronous).
- Counter wrap: CNTW=4, 17 skewed rows streamed with row_ready_i=1 -> rows_out_o reads 1 after the 17th accept.

Source files
------------

// File: rtl/syst_pkg.sv
// ---------------------------------------------------------------------------
// syst_pkg: definitions shared by the systolic-array output collector.
//   COLS_DEF / DW_DEF : default column count and per-column result width.
//   col_word_t        : one column result.
//   row_word_t        : one aligned row, column 0 in the least significant slot.
//   occ_width()       : occupancy counter width for a FIFO of a given depth
//                       (one extra bit so that "full" can be told from "empty").
// ---------------------------------------------------------------------------
package syst_pkg;

    localparam int COLS_DEF = 5;
    localparam int DW_DEF   = 20;

    typedef logic [DW_DEF-1:0]          col_word_t;
    typedef col_word_t [COLS_DEF-1:0]   row_word_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/syst_col_fifo.sv
// ---------------------------------------------------------------------------
// syst_col_fifo: single-column synchronous FIFO with a sticky overflow flag.
//   clk_i    : clock, rising edge.
//   rst_i    : asynchronous active-low reset.
//   flush_i  : synchronous clear of pointers, occupancy and overflow flag;
//              wins over push and pop in the same cycle.
//   push_i   : write din_i at the tail (accepted if not full, or if a pop
//              frees the slot in the same cycle).
//   din_i    : data to push.
//   pop_i    : drop the head entry (ignored while empty).
//   full_o   : occupancy == DEPTH.
//   empty_o  : occupancy == 0.
//   head_o   : entry at the head; meaningful only while not empty.
//   ovf_o    : set by a push to a full FIFO without a concurrent pop.
// ---------------------------------------------------------------------------
module syst_col_fifo
    import syst_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o,
    output logic          ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [OW-1:0] r_occ;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_occ == OW'(DEPTH));
    assign w_empty = (r_occ == '0);

    // A pop in the same cycle frees the slot, so a full FIFO still takes
    // the push; only an unmatched push to a full FIFO is lost.
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);
    assign w_drop  = push_i & w_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_ovf  <= 1'b0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr] <= din_i;
        end
    end

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign head_o  = r_mem[r_rptr];
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/syst_out_deskew.sv
// ---------------------------------------------------------------------------
// syst_out_deskew: re-aligns the time-skewed columns of the systolic array
// into whole rows and hands them downstream over valid/ready.
//   clk_i        : clock, rising edge.
//   rst_i        : asynchronous active-low reset.
//   flush_i      : synchronous clear of all FIFOs, overflow flags, counter.
//   y_i          : column results, column j at [j*DW +: DW].
//   yvalid_i     : per-column write strobes.
//   row_o        : aligned row (same packing as y_i), zero when not valid.
//   row_valid_o  : every column FIFO holds at least one entry.
//   row_ready_i  : downstream accepts row_o.
//   rows_out_o   : accepted-row counter, wraps silently.
//   ovf_o        : sticky per-column overflow flags.
//   idle_o       : every column FIFO is empty.
// ---------------------------------------------------------------------------
module syst_out_deskew
    import syst_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [COLS*DW-1:0] y_i,
    input  logic [COLS-1:0]    yvalid_i,
    output logic [COLS*DW-1:0] row_o,
    output logic               row_valid_o,
    input  logic               row_ready_i,
    output logic [CNTW-1:0]    rows_out_o,
    output logic [COLS-1:0]    ovf_o,
    output logic               idle_o
);

    logic [COLS-1:0] w_full;
    logic [COLS-1:0] w_empty;
    logic [DW-1:0]   w_head [COLS];
    logic            w_valid;
    logic            w_fire;
    logic [CNTW-1:0] r_rows;

    // Validity comes only from registered occupancy, never from yvalid_i.
    assign w_valid = ~|w_empty;
    assign w_fire  = w_valid & row_ready_i;

    for (genvar j = 0; j < COLS; j++) begin : g_col
        syst_col_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (yvalid_i[j]),
            .din_i   (y_i[j*DW +: DW]),
            .pop_i   (w_fire),
            .full_o  (w_full[j]),
            .empty_o (w_empty[j]),
            .head_o  (w_head[j]),
            .ovf_o   (ovf_o[j])
        );

        a_full_not_empty: assert property (
            @(posedge clk_i) disable iff (!rst_i) !(w_full[j] && w_empty[j])
        );
    end

    always_comb begin
        row_o = '0;
        if (w_valid) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                row_o[j*DW +: DW] = w_head[j];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rows <= '0;
        end else if (flush_i) begin
            r_rows <= '0;
        end else if (w_fire) begin
            r_rows <= r_rows + CNTW'(1);
        end
    end

    assign row_valid_o = w_valid;
    assign rows_out_o  = r_rows;
    assign idle_o      = &w_empty;

endmodule

// File: tb/tb_syst_out_deskew.sv
module tb_syst_out_deskew;

    localparam int COLS  = 5;
    localparam int DW    = 20;
    localparam int DEPTH = 8;
    localparam int CNTW  = 4;

    logic               clk;
    logic               rst_i;
    logic               flush_i;
    logic [COLS*DW-1:0] y_i;
    logic [COLS-1:0]    yvalid_i;
    logic [COLS*DW-1:0] row_o;
    logic               row_valid_o;
    logic               row_ready_i;
    logic [CNTW-1:0]    rows_out_o;
    logic [COLS-1:0]    ovf_o;
    logic               idle_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [COLS*DW-1:0] exp_q [$];

    syst_out_deskew #(
        .COLS  (COLS),
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .y_i         (y_i),
        .yvalid_i    (yvalid_i),
        .row_o       (row_o),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .rows_out_o  (rows_out_o),
        .ovf_o       (ovf_o),
        .idle_o      (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [COLS*DW-1:0] mkrow(input int r, input int off);
        logic [COLS*DW-1:0] w;
        w = '0;
        for (int j = 0; j < COLS; j++) w[j*DW +: DW] = DW'(10*r + j + off);
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
    endtask

    // Skewed stream: row r column j is presented in cycle r+j.
    task automatic stream(input int n, input int off);
        for (int r = 0; r < n; r++) exp_q.push_back(mkrow(r, off));
        for (int c = 0; c < n + COLS - 1; c++) begin
            yvalid_i = '0;
            y_i      = '0;
            for (int j = 0; j < COLS; j++) begin
                if (c - j >= 0 && c - j < n) begin
                    yvalid_i[j]     = 1'b1;
                    y_i[j*DW +: DW] = DW'(10*(c - j) + j + off);
                end
            end
            tick;
        end
        yvalid_i = '0;
        y_i      = '0;
    endtask

    // Scoreboard monitor: every accepted row is checked against the queue.
    always @(negedge clk) begin
        if (rst_i && !flush_i && row_valid_o && row_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_row", row_o, '0);
                n_err += (row_o === '0) ? 1 : 0;
            end else begin
                chk("row_data", row_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; y_i = '0; yvalid_i = '0; row_ready_i = 1'b0;
        #3;
        chk("rst_valid", row_valid_o, 0);
        chk("rst_row",   row_o, 0);
        chk("rst_rows",  rows_out_o, 0);
        chk("rst_ovf",   ovf_o, 0);
        chk("rst_idle",  idle_o, 1);
        #10 rst_i = 1'b1;
        tick;

        // Single skewed row
        row_ready_i = 1'b1;
        stream(1, 1);
        chk("t1_valid_rise", row_valid_o, 1);
        chk("t1_row", row_o, 100'h00005_00004_00003_00002_00001);
        tick;
        chk("t1_valid_fall", row_valid_o, 0);
        chk("t1_rows", rows_out_o, 1);
        chk("t1_idle", idle_o, 1);

        // Backpressure: three rows held, then drained back-to-back
        do_flush;
        row_ready_i = 1'b0;
        stream(3, 0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid_hold", row_valid_o, 1);
            chk("bp_row_stable", row_o, 100'h00004_00003_00002_00001_00000);
            tick;
        end
        row_ready_i = 1'b1;
        tick;
        chk("bp_rows1", rows_out_o, 1);
        chk("bp_valid_next", row_valid_o, 1);
        tick;
        tick;
        chk("bp_rows3", rows_out_o, 3);
        chk("bp_drained", row_valid_o, 0);
        chk("bp_idle", idle_o, 1);

        // Overflow: nine pushes into column 0 only
        do_flush;
        row_ready_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            yvalid_i = 5'b00001;
            y_i = '0;
            y_i[0 +: DW] = DW'(100 + k);
            tick;
        end
        yvalid_i = '0;
        chk("ovf_flag", ovf_o, 5'b00001);
        chk("ovf_novalid", row_valid_o, 0);
        chk("ovf_notidle", idle_o, 0);
        for (int k = 0; k < 8; k++) begin
            logic [COLS*DW-1:0] w;
            w = '0;
            w[0 +: DW] = DW'(100 + k);
            yvalid_i = 5'b11110;
            y_i = '0;
            for (int j = 1; j < COLS; j++) begin
                y_i[j*DW +: DW] = DW'(200 + 10*k + j);
                w[j*DW +: DW]   = DW'(200 + 10*k + j);
            end
            exp_q.push_back(w);
            tick;
        end
        yvalid_i = '0;
        y_i = '0;
        row_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) tick;
        chk("ovf_idle_after8", idle_o, 1);
        chk("ovf_rows8", rows_out_o, 8);
        chk("ovf_sticky", ovf_o, 5'b00001);
        do_flush;
        chk("ovf_flush_clr", ovf_o, 0);
        chk("ovf_flush_idle", idle_o, 1);

        // Full FIFOs with a concurrent pop and push
        row_ready_i = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            if (k == DEPTH) row_ready_i = 1'b1;
            yvalid_i = '1;
            y_i = mkrow(k, 300);
            exp_q.push_back(mkrow(k, 300));
            tick;
            if (k == DEPTH - 1) chk("full_valid", row_valid_o, 1);
        end
        yvalid_i = '0;
        y_i = '0;
        chk("full_noovf", ovf_o, 0);
        for (int k = 0; k < DEPTH; k++) tick;
        chk("full_rows9", rows_out_o, 9);
        chk("full_idle", idle_o, 1);

        // Flush beats a simultaneous push and pop
        row_ready_i = 1'b0;
        yvalid_i = '1;
        y_i = mkrow(0, 400);
        tick;
        chk("fl_valid_before", row_valid_o, 1);
        row_ready_i = 1'b1;
        flush_i = 1'b1;
        y_i = mkrow(1, 400);
        tick;
        flush_i = 1'b0;
        yvalid_i = '0;
        y_i = '0;
        chk("fl_idle", idle_o, 1);
        chk("fl_valid", row_valid_o, 0);
        chk("fl_rows", rows_out_o, 0);

        // Asynchronous reset after a partial row
        for (int c = 0; c < 3; c++) begin
            yvalid_i = '0;
            yvalid_i[c] = 1'b1;
            y_i = '0;
            y_i[c*DW +: DW] = DW'(700 + c);
            tick;
        end
        yvalid_i = '0;
        y_i = '0;
        chk("mr_partial_busy", idle_o, 0);
        #2 rst_i = 1'b0;
        #1;
        chk("mr_valid", row_valid_o, 0);
        chk("mr_idle", idle_o, 1);
        #3 rst_i = 1'b1;
        tick;

        // Counter wrap at 2^CNTW
        stream(17, 50);
        tick;
        tick;
        chk("wrap_rows", rows_out_o, 1);
        chk("wrap_idle", idle_o, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
